// File: rtl/aes_pkg.sv
// Shared types for the AES request dispatcher: opcodes, FSM state encoding,
// completion classification and a saturating counter helper.
package aes_pkg;

    localparam int AES_128 = 128;

    typedef enum logic [1:0] {
        OP_NOP     = 2'b00,
        OP_KEY     = 2'b01,
        OP_ENC     = 2'b10,
        OP_KEY_ENC = 2'b11
    } opcode_e;

    typedef enum logic [1:0] {
        CMPL_NONE   = 2'd0,
        CMPL_KEY    = 2'd1,
        CMPL_CIPHER = 2'd2
    } cmpl_e;

    typedef logic [1:0] disp_state_t;
    localparam disp_state_t ST_IDLE  = 2'd0;
    localparam disp_state_t ST_ISSUE = 2'd1;
    localparam disp_state_t ST_WAIT  = 2'd2;
    localparam disp_state_t ST_RESP  = 2'd3;

    function automatic cmpl_e cmpl_type(input opcode_e op);
        cmpl_e res;
        case (op)
            OP_NOP:     res = CMPL_NONE;
            OP_KEY:     res = CMPL_KEY;
            OP_ENC:     res = CMPL_CIPHER;
            OP_KEY_ENC: res = CMPL_CIPHER;
            default:    res = CMPL_NONE;
        endcase
        return res;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/aes_req_fifo.sv
// Single-channel synchronous FIFO with first-word fall-through read data.
// DEPTH must be a power of two so the pointers wrap naturally.
module aes_req_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic          do_push_s;
    logic          do_pop_s;

    assign full      = (count_r == (AW+1)'(DEPTH));
    assign empty     = (count_r == '0);
    assign do_push_s = push & ~full;
    assign do_pop_s  = pop & ~empty;
    assign rdata     = mem_r[rd_ptr_r];

    // Pointer and occupancy tracking.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; contents are don't-care while the slot is empty.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

endmodule

// File: rtl/aes_req_dispatcher.sv
// Multi-channel round-robin request front-end for the AES core.
// Optional AES_DISP_STATS_EN adds saturating per-channel done and timeout counters.
module aes_req_dispatcher
    import aes_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int FIFO_DEPTH  = 4,
    parameter int DATA_W      = AES_128,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                     clk,
    input  logic                     nrst,
    input  logic [NUM_CH-1:0]        req_valid_i,
    output logic [NUM_CH-1:0]        req_ready_o,
    input  logic [NUM_CH*2-1:0]      req_opcode_i,
    input  logic [NUM_CH*DATA_W-1:0] req_key_i,
    input  logic [NUM_CH*DATA_W-1:0] req_data_i,
    output logic                     core_start_o,
    output logic [1:0]               core_opcode_o,
    output logic [DATA_W-1:0]        core_key_o,
    output logic [DATA_W-1:0]        core_data_o,
    input  logic                     core_busy_i,
    input  logic                     core_key_ready_i,
    input  logic                     core_cipher_ready_i,
    input  logic [DATA_W-1:0]        core_cipher_i,
    output logic                     rsp_valid_o,
    input  logic                     rsp_ready_i,
    output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] rsp_ch_o,
    output logic [DATA_W-1:0]        rsp_data_o,
    output logic                     rsp_timeout_o
`ifdef AES_DISP_STATS_EN
    ,
    output logic [NUM_CH*16-1:0]     stat_done_o,
    output logic [15:0]              stat_timeout_o
`endif
);

    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int ENT_W = 2 + 2 * DATA_W;
    localparam int TMR_W = $clog2(TIMEOUT_CYC);

    logic [NUM_CH-1:0] full_s;
    logic [NUM_CH-1:0] empty_s;
    logic [NUM_CH-1:0] push_s;
    logic [NUM_CH-1:0] pop_s;
    logic [ENT_W-1:0]  fifo_rdata_s [NUM_CH];
    logic [ENT_W-1:0]  sel_s;
    logic              any_s;
    logic              grant_en_s;
    logic [CH_W-1:0]   grant_s;
    logic              done_s;
    cmpl_e             cmpl_cur_s;

    disp_state_t       state_r;
    logic [TMR_W-1:0]  timer_r;
    logic [CH_W-1:0]   rr_ptr_r;
    logic              start_r;
    logic [1:0]        core_opcode_r;
    logic [DATA_W-1:0] core_key_r;
    logic [DATA_W-1:0] core_data_r;
    logic              rsp_valid_r;
    logic [CH_W-1:0]   rsp_ch_r;
    logic [DATA_W-1:0] rsp_data_r;
    logic              rsp_timeout_r;

    // Ready depends only on registered FIFO occupancy, never on req_valid_i.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign push_s[c] = req_valid_i[c] & ~full_s[c];

        aes_req_fifo #(
            .DEPTH (FIFO_DEPTH),
            .W     (ENT_W)
        ) u_fifo (
            .clk   (clk),
            .nrst  (nrst),
            .push  (push_s[c]),
            .pop   (pop_s[c]),
            .wdata ({req_opcode_i[2*c +: 2], req_key_i[c*DATA_W +: DATA_W],
                     req_data_i[c*DATA_W +: DATA_W]}),
            .rdata (fifo_rdata_s[c]),
            .full  (full_s[c]),
            .empty (empty_s[c])
        );
    end

    assign req_ready_o   = ~full_s;
    assign core_start_o  = start_r;
    assign core_opcode_o = core_opcode_r;
    assign core_key_o    = core_key_r;
    assign core_data_o   = core_data_r;
    assign rsp_valid_o   = rsp_valid_r;
    assign rsp_ch_o      = rsp_ch_r;
    assign rsp_data_o    = rsp_data_r;
    assign rsp_timeout_o = rsp_timeout_r;

    // Round-robin search: first non-empty channel at or after rr_ptr_r.
    always_comb begin
        int idx;
        any_s   = 1'b0;
        grant_s = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = int'(rr_ptr_r) + i;
            if (idx >= NUM_CH) begin
                idx = idx - NUM_CH;
            end else begin
                idx = idx;
            end
            if (!any_s && !empty_s[idx]) begin
                any_s   = 1'b1;
                grant_s = CH_W'(idx);
            end else begin
                any_s   = any_s;
            end
        end
    end

    assign grant_en_s = (state_r == ST_IDLE) & any_s & ~core_busy_i;
    assign sel_s      = fifo_rdata_s[grant_s];
    assign cmpl_cur_s = cmpl_type(opcode_e'(core_opcode_r));

    // Pop strobe for the granted FIFO.
    always_comb begin
        pop_s = '0;
        if (grant_en_s) begin
            pop_s[grant_s] = 1'b1;
        end else begin
            pop_s = '0;
        end
    end

    // Only the strobe matching the outstanding opcode completes it.
    always_comb begin
        case (cmpl_cur_s)
            CMPL_KEY:    done_s = core_key_ready_i;
            CMPL_CIPHER: done_s = core_cipher_ready_i;
            default:     done_s = 1'b0;
        endcase
    end

    // Dispatcher FSM with registered core and response outputs.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_r       <= ST_IDLE;
            timer_r       <= '0;
            rr_ptr_r      <= '0;
            start_r       <= 1'b0;
            core_opcode_r <= 2'b00;
            core_key_r    <= '0;
            core_data_r   <= '0;
            rsp_valid_r   <= 1'b0;
            rsp_ch_r      <= '0;
            rsp_data_r    <= '0;
            rsp_timeout_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (grant_en_s) begin
                        core_opcode_r <= sel_s[ENT_W-1 -: 2];
                        core_key_r    <= sel_s[2*DATA_W-1 -: DATA_W];
                        core_data_r   <= sel_s[DATA_W-1:0];
                        rsp_ch_r      <= grant_s;
                        rr_ptr_r      <= (int'(grant_s) == NUM_CH - 1) ? '0 : grant_s + CH_W'(1);
                        // NOPs never reach the core
                        if (cmpl_type(opcode_e'(sel_s[ENT_W-1 -: 2])) == CMPL_NONE) begin
                            rsp_data_r    <= '0;
                            rsp_timeout_r <= 1'b0;
                            rsp_valid_r   <= 1'b1;
                            state_r       <= ST_RESP;
                        end else begin
                            start_r <= 1'b1;
                            state_r <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    start_r <= 1'b0;
                    timer_r <= '0;
                    state_r <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (done_s) begin
                        rsp_data_r    <= (cmpl_cur_s == CMPL_KEY) ? '0 : core_cipher_i;
                        rsp_timeout_r <= 1'b0;
                        rsp_valid_r   <= 1'b1;
                        state_r       <= ST_RESP;
                    end else if (timer_r == TMR_W'(TIMEOUT_CYC - 1)) begin
                        rsp_data_r    <= '0;
                        rsp_timeout_r <= 1'b1;
                        rsp_valid_r   <= 1'b1;
                        state_r       <= ST_RESP;
                    end else begin
                        timer_r <= timer_r + TMR_W'(1);
                    end
                end
                ST_RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_r <= 1'b0;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    start_r     <= 1'b0;
                    rsp_valid_r <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef AES_DISP_STATS_EN
    logic [15:0] stat_done_r [NUM_CH];
    logic [15:0] stat_timeout_r;
    logic        rsp_hs_s;

    assign rsp_hs_s = rsp_valid_r & rsp_ready_i;

    // Saturating response statistics, updated on each response handshake.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                stat_done_r[c] <= 16'd0;
            end
            stat_timeout_r <= 16'd0;
        end else if (rsp_hs_s) begin
            if (rsp_timeout_r) begin
                stat_timeout_r <= sat_inc16(stat_timeout_r);
            end else begin
                stat_done_r[rsp_ch_r] <= sat_inc16(stat_done_r[rsp_ch_r]);
            end
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_stat
        assign stat_done_o[c*16 +: 16] = stat_done_r[c];
    end
    assign stat_timeout_o = stat_timeout_r;
`else
    // Statistics counters are absent in this build.
`endif

endmodule

// File: tb/tb_aes_req_dispatcher.sv
// Scoreboard bench for aes_req_dispatcher with a small behavioural AES core model.
module tb_aes_req_dispatcher;
    import aes_pkg::*;

    localparam int NCH = 4;
    localparam int DW  = 128;
    localparam logic [127:0] JUNK = 128'hdeadbeef_deadbeef_deadbeef_deadbeef;
    localparam logic [127:0] MIX  = 128'h5a5a5a5a_5a5a5a5a_5a5a5a5a_5a5a5a5a;

    logic              clk = 1'b0;
    logic              nrst = 1'b0;
    logic [NCH-1:0]    req_valid_i = '0;
    logic [NCH-1:0]    req_ready_o;
    logic [NCH*2-1:0]  req_opcode_i = '0;
    logic [NCH*DW-1:0] req_key_i = '0;
    logic [NCH*DW-1:0] req_data_i = '0;
    logic              core_start_o;
    logic [1:0]        core_opcode_o;
    logic [DW-1:0]     core_key_o;
    logic [DW-1:0]     core_data_o;
    logic              core_busy_i = 1'b0;
    logic              core_key_ready_i;
    logic              core_cipher_ready_i;
    logic [DW-1:0]     core_cipher_i;
    logic              rsp_valid_o;
    logic              rsp_ready_i = 1'b1;
    logic [1:0]        rsp_ch_o;
    logic [DW-1:0]     rsp_data_o;
    logic              rsp_timeout_o;

    aes_req_dispatcher #(.NUM_CH(NCH), .FIFO_DEPTH(4), .DATA_W(DW), .TIMEOUT_CYC(64)) dut (
        .clk(clk), .nrst(nrst),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_opcode_i(req_opcode_i),
        .req_key_i(req_key_i), .req_data_i(req_data_i),
        .core_start_o(core_start_o), .core_opcode_o(core_opcode_o), .core_key_o(core_key_o),
        .core_data_o(core_data_o), .core_busy_i(core_busy_i), .core_key_ready_i(core_key_ready_i),
        .core_cipher_ready_i(core_cipher_ready_i), .core_cipher_i(core_cipher_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_ch_o(rsp_ch_o),
        .rsp_data_o(rsp_data_o), .rsp_timeout_o(rsp_timeout_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]   ch;
        logic [127:0] data;
        logic         to;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   start_cnt = 0;
    int   hs_cnt = 0;
    int   core_mode = 0;   // 0 correct strobe, 1 wrong strobe, 2 silent
    int   core_dly = 3;    // cycles from start pulse to strobe

    function automatic logic [127:0] cmodel(input logic [127:0] k, input logic [127:0] d);
        return k ^ {d[63:0], d[127:64]} ^ MIX;
    endfunction

    function automatic logic [1:0] strobes(input logic [1:0] op, input int mode);
        if (mode == 2) return 2'b00;
        if (op == OP_KEY) return (mode == 0) ? 2'b10 : 2'b01;
        return (mode == 0) ? 2'b01 : 2'b10;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Behavioural core: strobe core_dly cycles after the start pulse
    logic [1:0]   m_op;
    logic [127:0] m_key, m_data;
    int           m_cnt;
    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            m_cnt <= 0;
            core_key_ready_i <= 1'b0;
            core_cipher_ready_i <= 1'b0;
            core_cipher_i <= JUNK;
        end else begin
            core_key_ready_i <= 1'b0;
            core_cipher_ready_i <= 1'b0;
            core_cipher_i <= JUNK;
            if (core_start_o) begin
                m_op <= core_opcode_o;
                m_key <= core_key_o;
                m_data <= core_data_o;
                if (core_dly == 1) begin
                    {core_key_ready_i, core_cipher_ready_i} <= strobes(core_opcode_o, core_mode);
                    core_cipher_i <= cmodel(core_key_o, core_data_o);
                end else begin
                    m_cnt <= core_dly - 1;
                end
            end else if (m_cnt > 0) begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) begin
                    {core_key_ready_i, core_cipher_ready_i} <= strobes(m_op, core_mode);
                    core_cipher_i <= cmodel(m_key, m_data);
                end
            end
        end
    end

    // Response monitor: pops the scoreboard on each handshake
    always @(negedge clk) begin
        #1;
        if (core_start_o) start_cnt++;
        if (nrst && rsp_valid_o && rsp_ready_i) begin
            hs_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got ch=%0d data=%h expected no response", rsp_ch_o, rsp_data_o);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rsp_ch", 128'(rsp_ch_o), 128'(e.ch));
                chk("rsp_data", rsp_data_o, e.data);
                chk("rsp_timeout", 128'(rsp_timeout_o), 128'(e.to));
            end
        end
    end

    task automatic set_req(input int ch, input logic [1:0] op, input logic [127:0] k, input logic [127:0] d);
        req_opcode_i[2*ch +: 2] = op;
        req_key_i[ch*DW +: DW] = k;
        req_data_i[ch*DW +: DW] = d;
    endtask

    task automatic push_exp(input int ch, input logic [127:0] d, input logic to);
        exp_t e;
        e.ch = 2'(ch);
        e.data = d;
        e.to = to;
        exp_q.push_back(e);
    endtask

    task automatic wait_drain(input string nm);
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk(nm, 128'(exp_q.size()), 128'd0);
        @(negedge clk);
    endtask

    task automatic wait_start(input string nm);
        int n = 0;
        while (!core_start_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(nm, 128'(core_start_o), 128'd1);
    endtask

    initial begin
        logic [127:0] k, d, k1, d1, k3, d3;
        int s0, h0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ready", 128'(req_ready_o), 128'hF);
        chk("rst_start", 128'(core_start_o), 128'd0);
        chk("rst_valid", 128'(rsp_valid_o), 128'd0);
        chk("rst_rsp_data", rsp_data_o, 128'd0);
        chk("rst_core_key", core_key_o, 128'd0);
        nrst = 1'b1;
        @(negedge clk);

        // Single OP_ENC on ch2, 3-cycle core: start at N+2, response at N+6
        k1 = 128'h00010203_04050607_08090a0b_0c0d0e0f;
        d1 = 128'h00112233_44556677_8899aabb_ccddeeff;
        set_req(2, OP_ENC, k1, d1);
        push_exp(2, cmodel(k1, d1), 1'b0);
        req_valid_i = 4'b0100;
        @(negedge clk);
        req_valid_i = 4'b0000;
        chk("start_n1", 128'(core_start_o), 128'd0);
        @(negedge clk);
        chk("start_n2", 128'(core_start_o), 128'd1);
        chk("core_opcode", 128'(core_opcode_o), 128'(OP_ENC));
        chk("core_key", core_key_o, k1);
        chk("core_data", core_data_o, d1);
        @(negedge clk);
        chk("start_n3", 128'(core_start_o), 128'd0);
        repeat (2) @(negedge clk);
        chk("rsp_n5", 128'(rsp_valid_o), 128'd0);
        @(negedge clk);
        chk("rsp_n6", 128'(rsp_valid_o), 128'd1);
        wait_drain("drain_t1");

        // Minimum latency: completion at N+3, response at N+4
        core_dly = 1;
        set_req(3, OP_KEY_ENC, ~k1, d1);
        push_exp(3, cmodel(~k1, d1), 1'b0);
        req_valid_i = 4'b1000;
        @(negedge clk);
        req_valid_i = 4'b0000;
        repeat (2) @(negedge clk);
        chk("minlat_n3", 128'(rsp_valid_o), 128'd0);
        @(negedge clk);
        chk("minlat_n4", 128'(rsp_valid_o), 128'd1);
        wait_drain("drain_t1b");

        // Round robin: all four at once, then ch3+ch1, plus a NOP
        core_dly = 2;
        for (int c = 0; c < NCH; c++) begin
            k = {16{8'(c + 8'h40)}};
            d = {16{8'(c + 8'h80)}};
            set_req(c, (c == 2) ? OP_NOP : ((c == 1) ? OP_KEY : OP_ENC), k, d);
            push_exp(c, (c == 2 || c == 1) ? 128'd0 : cmodel(k, d), 1'b0);
        end
        req_valid_i = 4'b1111;
        @(negedge clk);
        req_valid_i = 4'b0000;
        wait_drain("drain_wave1");
        set_req(3, OP_ENC, k1, ~d1);
        set_req(1, OP_ENC, ~k1, ~d1);
        push_exp(1, cmodel(~k1, ~d1), 1'b0);
        push_exp(3, cmodel(k1, ~d1), 1'b0);
        req_valid_i = 4'b1010;
        @(negedge clk);
        req_valid_i = 4'b0000;
        wait_drain("drain_wave2");

        // FIFO full on ch0 while the core is busy
        core_busy_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            k = {16{8'(i + 8'h10)}};
            d = {16{8'(i + 8'hA0)}};
            set_req(0, OP_ENC, k, d);
            push_exp(0, cmodel(k, d), 1'b0);
            req_valid_i = 4'b0001;
            @(negedge clk);
        end
        chk("full_after4", 128'(req_ready_o[0]), 128'd0);
        set_req(0, OP_ENC, JUNK, JUNK);
        @(negedge clk);
        chk("full_hold", 128'(req_ready_o[0]), 128'd0);
        chk("full_no_start", 128'(core_start_o), 128'd0);
        req_valid_i = 4'b0000;
        core_busy_i = 1'b0;
        @(negedge clk);
        chk("ready_after_pop", 128'(req_ready_o[0]), 128'd1);
        wait_drain("drain_full");

        // Timeout: OP_KEY answered only with the non-matching strobe
        core_mode = 1;
        set_req(1, OP_KEY, k1, d1);
        push_exp(1, 128'd0, 1'b1);
        req_valid_i = 4'b0010;
        @(negedge clk);
        req_valid_i = 4'b0000;
        wait_start("to_start");
        repeat (64) @(negedge clk);
        chk("to_wait64", 128'(rsp_valid_o), 128'd0);
        @(negedge clk);
        chk("to_rsp", 128'(rsp_valid_o), 128'd1);
        wait_drain("drain_to");
        core_mode = 0;
        set_req(1, OP_KEY, d1, k1);
        push_exp(1, 128'd0, 1'b0);
        req_valid_i = 4'b0010;
        @(negedge clk);
        req_valid_i = 4'b0000;
        wait_drain("drain_after_to");

        // Response backpressure for 10 cycles; ch3 then ch0 (pointer at 2)
        rsp_ready_i = 1'b0;
        k3 = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
        d3 = 128'hffeeddcc_bbaa9988_77665544_33221100;
        set_req(3, OP_ENC, k3, d3);
        set_req(0, OP_ENC, d3, k3);
        push_exp(3, cmodel(k3, d3), 1'b0);
        push_exp(0, cmodel(d3, k3), 1'b0);
        req_valid_i = 4'b1001;
        @(negedge clk);
        req_valid_i = 4'b0000;
        for (int n = 0; n < 200 && !rsp_valid_o; n++) @(negedge clk);
        for (int n = 0; n < 10; n++) begin
            chk("bp_valid", 128'(rsp_valid_o), 128'd1);
            chk("bp_ch", 128'(rsp_ch_o), 128'd3);
            chk("bp_data", rsp_data_o, cmodel(k3, d3));
            chk("bp_no_start", 128'(core_start_o), 128'd0);
            @(negedge clk);
        end
        rsp_ready_i = 1'b1;
        @(negedge clk);
        chk("bp_idle_valid", 128'(rsp_valid_o), 128'd0);
        chk("bp_idle_start", 128'(core_start_o), 128'd0);
        @(negedge clk);
        chk("bp_next_grant", 128'(core_start_o), 128'd1);
        wait_drain("drain_bp");

        // Reset during WAIT drops the in-flight and the queued request
        core_mode = 2;
        set_req(0, OP_ENC, k1, d1);
        req_valid_i = 4'b0001;
        @(negedge clk);
        req_valid_i = 4'b0000;
        wait_start("rst_mid_start");
        @(negedge clk);
        set_req(1, OP_ENC, k3, d3);
        req_valid_i = 4'b0010;
        @(negedge clk);
        req_valid_i = 4'b0000;
        #2 nrst = 1'b0;
        #1;
        chk("rstw_start", 128'(core_start_o), 128'd0);
        chk("rstw_valid", 128'(rsp_valid_o), 128'd0);
        chk("rstw_ready", 128'(req_ready_o), 128'hF);
        s0 = start_cnt;
        h0 = hs_cnt;
        @(negedge clk);
        nrst = 1'b1;
        core_mode = 0;
        repeat (30) @(negedge clk);
        chk("rstw_no_start", 128'(start_cnt), 128'(s0));
        chk("rstw_no_rsp", 128'(hs_cnt), 128'(h0));
        chk("sb_empty", 128'(exp_q.size()), 128'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
